// File: rtl/seq_alu.sv
// seq_alu: multi-cycle integer ALU for the execute stage.
// Single-cycle RV32I ops, iterative shift-add multiply and restoring divide.
// One operation in flight; valid/ready handshake on both sides.
// Handshake: a transfer happens on a rising edge where valid && ready; the
// producer holds valid and its payload stable until that edge.
// Build option: define SEQ_ALU_DIV_EN to compile in the divider datapath and
// DIV state; without it DIV/DIVU/REM/REMU report op_err like unknown opcodes.
module seq_alu #(
    parameter int XLEN               = 32,
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5:0]      alu_op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            op_err,
    output logic [1:0]      state_dbg
);
    // Opcode values shared with constants.v
    localparam logic [5:0] OP_ADD    = 6'd0;
    localparam logic [5:0] OP_SUB    = 6'd1;
    localparam logic [5:0] OP_SLT    = 6'd2;
    localparam logic [5:0] OP_SLTU   = 6'd3;
    localparam logic [5:0] OP_AND    = 6'd4;
    localparam logic [5:0] OP_OR     = 6'd5;
    localparam logic [5:0] OP_XOR    = 6'd6;
    localparam logic [5:0] OP_SLL    = 6'd7;
    localparam logic [5:0] OP_SRL    = 6'd8;
    localparam logic [5:0] OP_SRA    = 6'd9;
    localparam logic [5:0] OP_MUL    = 6'd10;
    localparam logic [5:0] OP_MULH   = 6'd11;
    localparam logic [5:0] OP_MULHSU = 6'd12;
    localparam logic [5:0] OP_MULHU  = 6'd13;
`ifdef SEQ_ALU_DIV_EN
    localparam logic [5:0] OP_DIV    = 6'd14;
    localparam logic [5:0] OP_DIVU   = 6'd15;
    localparam logic [5:0] OP_REM    = 6'd16;
    localparam logic [5:0] OP_REMU   = 6'd17;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
`endif

    localparam int SHW = $clog2(XLEN);
    localparam int MUL_STEPS = XLEN / MUL_BITS_PER_CYCLE;
    localparam logic [SHW-1:0] MUL_LAST = SHW'(MUL_STEPS - 1);
    localparam logic [SHW-1:0] DIV_LAST = SHW'(XLEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t            state, state_nxt, acc_state;
    logic              accept;
    logic [SHW-1:0]    cnt;
    logic [5:0]        op_q;
    logic [XLEN-1:0]   result_q, acc_result;
    logic              err_q, acc_err;
    logic              a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              neg_q;
    logic [2*XLEN-1:0] mul_acc, mul_m, mul_part, mul_acc_nxt, mul_prod;
    logic [XLEN-1:0]   mul_b;
`ifdef SEQ_ALU_DIV_EN
    logic [XLEN-1:0]   div_quo, div_dvs, div_rem, div_quo_nxt, div_rem_nxt;
    logic [XLEN:0]     div_shift, div_diff;
    logic [XLEN-1:0]   div_q_fix, div_r_fix;
    logic              negr_q;
`endif

    assign accept = in_valid && in_ready;

    // Decode the offered op: one-cycle result, fast paths, or the iterative state to enter
    always_comb begin
        acc_state  = S_DONE;
        acc_result = '0;
        acc_err    = 1'b0;
        case (alu_op)
            OP_ADD:  acc_result = a + b;
            OP_SUB:  acc_result = a - b;
            OP_SLT:  acc_result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: acc_result = {{(XLEN-1){1'b0}}, a < b};
            OP_AND:  acc_result = a & b;
            OP_OR:   acc_result = a | b;
            OP_XOR:  acc_result = a ^ b;
            OP_SLL:  acc_result = a << b[SHW-1:0];
            OP_SRL:  acc_result = a >> b[SHW-1:0];
            OP_SRA:  acc_result = $unsigned($signed(a) >>> b[SHW-1:0]);
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: acc_state = S_MUL;
`ifdef SEQ_ALU_DIV_EN
            OP_DIV, OP_REM: begin
                if (b == '0)
                    acc_result = (alu_op == OP_DIV) ? '1 : a;
                else if (a == MOST_NEG && b == '1)
                    acc_result = (alu_op == OP_DIV) ? a : '0;
                else
                    acc_state = S_DIV;
            end
            OP_DIVU, OP_REMU: begin
                if (b == '0)
                    acc_result = (alu_op == OP_DIVU) ? '1 : a;
                else
                    acc_state = S_DIV;
            end
`endif
            default: acc_err = 1'b1;
        endcase
    end

    // Operand signedness and magnitudes; iterative units work on magnitudes
    always_comb begin
        a_signed = (alu_op == OP_MULH) || (alu_op == OP_MULHSU);
        b_signed = (alu_op == OP_MULH);
`ifdef SEQ_ALU_DIV_EN
        if (alu_op == OP_DIV || alu_op == OP_REM) begin
            a_signed = 1'b1;
            b_signed = 1'b1;
        end
`endif
        a_neg = a_signed && a[XLEN-1];
        b_neg = b_signed && b[XLEN-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    // One shift-add step: add the multiplicand for each retired multiplier bit
    always_comb begin
        mul_part = '0;
        for (int j = 0; j < MUL_BITS_PER_CYCLE; j++)
            if (mul_b[j]) mul_part = mul_part + (mul_m << j);
        mul_acc_nxt = mul_acc + mul_part;
        mul_prod    = neg_q ? -mul_acc_nxt : mul_acc_nxt;
    end

`ifdef SEQ_ALU_DIV_EN
    // One restoring-division step plus the final sign fix-up
    always_comb begin
        div_shift   = {div_rem, div_quo[XLEN-1]};
        div_diff    = div_shift - {1'b0, div_dvs};
        div_rem_nxt = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
        div_quo_nxt = {div_quo[XLEN-2:0], ~div_diff[XLEN]};
        div_q_fix   = neg_q ? -div_quo_nxt : div_quo_nxt;
        div_r_fix   = negr_q ? -div_rem_nxt : div_rem_nxt;
    end
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = acc_state;
            S_MUL:  if (cnt == MUL_LAST) state_nxt = S_DONE;
            S_DIV:  if (cnt == DIV_LAST) state_nxt = S_DONE;
            S_DONE: begin
                if (accept)         state_nxt = acc_state;
                else if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs; in_ready takes the combinational path from out_ready
    always_comb begin
        in_ready  = (state == S_IDLE) || (state == S_DONE && out_ready);
        out_valid = (state == S_DONE);
        state_dbg = state;
    end

    // Datapath: capture on accept, iterate in MUL/DIV, hold the result in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            cnt      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            neg_q    <= 1'b0;
            mul_acc  <= '0;
            mul_m    <= '0;
            mul_b    <= '0;
`ifdef SEQ_ALU_DIV_EN
            div_quo  <= '0;
            div_dvs  <= '0;
            div_rem  <= '0;
            negr_q   <= 1'b0;
`endif
        end else if (accept) begin
            op_q     <= alu_op;
            cnt      <= '0;
            result_q <= acc_result;
            err_q    <= acc_err;
            neg_q    <= a_neg ^ b_neg;
            mul_acc  <= '0;
            mul_m    <= {{XLEN{1'b0}}, a_mag};
            mul_b    <= b_mag;
`ifdef SEQ_ALU_DIV_EN
            div_quo  <= a_mag;
            div_dvs  <= b_mag;
            div_rem  <= '0;
            negr_q   <= a_neg;
`endif
        end else if (state == S_MUL) begin
            cnt     <= cnt + 1'b1;
            mul_acc <= mul_acc_nxt;
            mul_m   <= mul_m << MUL_BITS_PER_CYCLE;
            mul_b   <= mul_b >> MUL_BITS_PER_CYCLE;
            if (cnt == MUL_LAST)
                result_q <= (op_q == OP_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
`ifdef SEQ_ALU_DIV_EN
        end else if (state == S_DIV) begin
            cnt     <= cnt + 1'b1;
            div_quo <= div_quo_nxt;
            div_rem <= div_rem_nxt;
            if (cnt == DIV_LAST)
                result_q <= (op_q == OP_DIV || op_q == OP_DIVU) ? div_q_fix : div_r_fix;
`endif
        end
    end

    assign result = result_q;
    assign op_err = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: vector table, scoreboard-checked random
// traffic under backpressure, hand sequences for hold/busy/reset, and a
// MUL_BITS_PER_CYCLE=4 instance for multiply latency.
module tb_seq_alu;
    localparam int XLEN = 32;

    localparam logic [5:0] OP_ADD = 6'd0,  OP_SUB = 6'd1,  OP_SLT = 6'd2,  OP_SLTU = 6'd3;
    localparam logic [5:0] OP_AND = 6'd4,  OP_OR = 6'd5,   OP_XOR = 6'd6,  OP_SLL = 6'd7;
    localparam logic [5:0] OP_SRL = 6'd8,  OP_SRA = 6'd9,  OP_MUL = 6'd10, OP_MULH = 6'd11;
    localparam logic [5:0] OP_MULHSU = 6'd12, OP_MULHU = 6'd13, OP_DIV = 6'd14, OP_DIVU = 6'd15;
    localparam logic [5:0] OP_REM = 6'd16, OP_REMU = 6'd17, OP_BAD = 6'd63;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    logic            in_valid, in_ready, out_valid, out_ready, op_err;
    logic [5:0]      alu_op;
    logic [XLEN-1:0] a, b, result;
    logic [1:0]      state_dbg;

    seq_alu #(.XLEN(XLEN), .MUL_BITS_PER_CYCLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .op_err(op_err), .state_dbg(state_dbg)
    );

    logic            in_valid4, in_ready4, out_valid4, out_ready4, op_err4;
    logic [5:0]      alu_op4;
    logic [XLEN-1:0] a4, b4, result4;
    logic [1:0]      state_dbg4;

    seq_alu #(.XLEN(XLEN), .MUL_BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .alu_op(alu_op4), .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4),
        .result(result4), .op_err(op_err4), .state_dbg(state_dbg4)
    );

    // ---------------- checking ----------------
    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Golden model built from plain SV arithmetic
    task automatic model(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output logic e, output int lat);
        logic signed [63:0] ps;
        logic [63:0]        pu;
        r = '0; e = 1'b0; lat = 1;
        case (op)
            OP_ADD:  r = x + y;
            OP_SUB:  r = x - y;
            OP_SLT:  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            OP_SLTU: r = (x < y) ? 32'd1 : 32'd0;
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_XOR:  r = x ^ y;
            OP_SLL:  r = x << y[4:0];
            OP_SRL:  r = x >> y[4:0];
            OP_SRA:  r = $unsigned($signed(x) >>> y[4:0]);
            OP_MUL, OP_MULH: begin
                ps = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
                r = (op == OP_MUL) ? ps[31:0] : ps[63:32];
                lat = 33;
            end
            OP_MULHSU: begin
                ps = $signed({{32{x[31]}}, x}) * $signed({32'd0, y});
                r = ps[63:32]; lat = 33;
            end
            OP_MULHU: begin
                pu = {32'd0, x} * {32'd0, y};
                r = pu[63:32]; lat = 33;
            end
`ifdef SEQ_ALU_DIV_EN
            OP_DIV, OP_REM: begin
                if (y == 0)
                    r = (op == OP_DIV) ? 32'hFFFFFFFF : x;
                else if (x == 32'h80000000 && y == 32'hFFFFFFFF)
                    r = (op == OP_DIV) ? x : 32'd0;
                else begin
                    r = (op == OP_DIV) ? $unsigned($signed(x) / $signed(y))
                                       : $unsigned($signed(x) % $signed(y));
                    lat = 33;
                end
            end
            OP_DIVU, OP_REMU: begin
                if (y == 0) r = (op == OP_DIVU) ? 32'hFFFFFFFF : x;
                else begin
                    r = (op == OP_DIVU) ? x / y : x % y;
                    lat = 33;
                end
            end
`endif
            default: e = 1'b1;
        endcase
    endtask

    // ---------------- scoreboard ----------------
    logic [XLEN:0] exp_q[$];
    int            acc_q[$];
    int            lat_q[$];
    string         name_q[$];

    logic          held = 1'b0;
    logic          hold_chk = 1'b0;
    int            vstart = 0;
    logic [XLEN:0] prev_out = '0;

    // Compare outputs on each handshake; between handshakes they must hold
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            held = 1'b0;
            hold_chk = 1'b0;
        end else begin
            if (hold_chk) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_result", {op_err, result}, prev_out);
            end
            if (out_valid && !held) begin
                held = 1'b1;
                vstart = cyc;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_output: got 0x%0h, expected no output", result);
                end else begin
                    logic [XLEN:0] ex;
                    int            ac, la;
                    string         nm;
                    ex = exp_q.pop_front(); ac = acc_q.pop_front();
                    la = lat_q.pop_front(); nm = name_q.pop_front();
                    chk(nm, {op_err, result}, ex);
                    chk({nm, "_lat"}, vstart - ac + 1, la);
                end
                held = 1'b0;
                hold_chk = 1'b0;
            end else begin
                hold_chk = out_valid;
                prev_out = {op_err, result};
            end
        end
    end

    // ---------------- drivers ----------------
    bit rdy_rand = 1'b0;
    initial forever begin
        @(negedge clk);
        if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic issue(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] er, input logic ee, input int el,
                         input string nm, input bit push, output int acc);
        int guard = 0;
        @(negedge clk);
        in_valid = 1'b1; alu_op = op; a = x; b = y;
        #1;
        while (!in_ready && guard < 300) begin
            @(negedge clk); #1; guard++;
        end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL %s_accept: in_ready stayed 0, expected 1", nm);
            acc = -1;
        end else begin
            acc = cyc + 1;
            if (push) begin
                exp_q.push_back({ee, er}); acc_q.push_back(acc);
                lat_q.push_back(el); name_q.push_back(nm);
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 3000) begin
            @(negedge clk); guard++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic mul4(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] er, input string nm);
        int acc, guard;
        guard = 0;
        @(negedge clk);
        in_valid4 = 1'b1; alu_op4 = op; a4 = x; b4 = y;
        #1;
        chk({nm, "_rdy"}, in_ready4, 1);
        acc = cyc + 1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        do begin
            @(negedge clk); #2; guard++;
        end while (!out_valid4 && guard < 100);
        chk(nm, {op_err4, result4}, {1'b0, er});
        chk({nm, "_lat"}, cyc - acc + 1, 9);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'd0;
            1: v = 32'd1;
            2: v = 32'hFFFFFFFF;
            3: v = 32'h80000000;
            4: v = 32'($urandom_range(0, 15));
            default: v = $urandom();
        endcase
        return v;
    endfunction

    typedef struct {
        logic [5:0]  op;
        logic [31:0] x, y, res;
        logic        err;
        int          lat;
        string       nm;
    } vec_t;
    vec_t vecs[$];

    // ---------------- main sequence ----------------
    initial begin
        int acc0, acc1, vcount;
        logic [31:0] er;
        logic ee;
        int el;
        logic [5:0] op;
        logic [31:0] x, y;

        rst_n = 1'b0; in_valid = 1'b0; alu_op = '0; a = '0; b = '0; out_ready = 1'b1;
        in_valid4 = 1'b0; alu_op4 = '0; a4 = '0; b4 = '0; out_ready4 = 1'b1;

        vecs.push_back('{OP_ADD,  32'd10,       32'd20,       32'd30,       1'b0, 1,  "add"});
        vecs.push_back('{OP_SUB,  32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 1,  "sub_wrap"});
        vecs.push_back('{OP_SRA,  32'h80000000, 32'd1,        32'hC0000000, 1'b0, 1,  "sra"});
        vecs.push_back('{OP_SLTU, 32'd1,        32'hFFFFFFFF, 32'd1,        1'b0, 1,  "sltu"});
        vecs.push_back('{OP_SLT,  32'hFFFFFFFF, 32'd0,        32'd1,        1'b0, 1,  "slt"});
        vecs.push_back('{OP_SLL,  32'hFFFFFFFF, 32'd33,       32'hFFFFFFFE, 1'b0, 1,  "sll_mask"});
        vecs.push_back('{OP_SRL,  32'h80000000, 32'd31,       32'd1,        1'b0, 1,  "srl"});
        vecs.push_back('{OP_AND,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1,  "and"});
        vecs.push_back('{OP_OR,   32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1'b0, 1,  "or"});
        vecs.push_back('{OP_XOR,  32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1'b0, 1,  "xor"});
        vecs.push_back('{OP_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        1'b0, 33, "mul_ff"});
        vecs.push_back('{OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        1'b0, 33, "mulh_ff"});
        vecs.push_back('{OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33, "mulhu_ff"});
        vecs.push_back('{OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 33, "mulhsu_ff"});
        vecs.push_back('{OP_MUL,  32'd3,        32'd4,        32'd12,       1'b0, 33, "mul_3x4"});
        vecs.push_back('{OP_MULH, 32'h80000000, 32'd2,        32'hFFFFFFFF, 1'b0, 33, "mulh_neg"});
        vecs.push_back('{OP_MULHU, 32'h80000000, 32'd2,       32'd1,        1'b0, 33, "mulhu_2"});
        vecs.push_back('{OP_BAD,  32'd1,        32'd2,        32'd0,        1'b1, 1,  "bad_op"});
`ifdef SEQ_ALU_DIV_EN
        vecs.push_back('{OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 33, "div_m7_2"});
        vecs.push_back('{OP_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 33, "rem_m7_2"});
        vecs.push_back('{OP_DIV,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 33, "div_7_m2"});
        vecs.push_back('{OP_REM,  32'd7,        32'hFFFFFFFE, 32'd1,        1'b0, 33, "rem_7_m2"});
        vecs.push_back('{OP_DIVU, 32'd100,      32'd7,        32'd14,       1'b0, 33, "divu_100_7"});
        vecs.push_back('{OP_REMU, 32'd100,      32'd7,        32'd2,        1'b0, 33, "remu_100_7"});
        vecs.push_back('{OP_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0, 1,  "divu_by0"});
        vecs.push_back('{OP_REM,  32'd5,        32'd0,        32'd5,        1'b0, 1,  "rem_by0"});
        vecs.push_back('{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1,  "div_ovf"});
        vecs.push_back('{OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0, 1,  "rem_ovf"});
`else
        vecs.push_back('{OP_DIVU, 32'd10,       32'd2,        32'd0,        1'b1, 1,  "divu_off"});
        vecs.push_back('{OP_DIV,  32'hFFFFFFF9, 32'd2,        32'd0,        1'b1, 1,  "div_off"});
        vecs.push_back('{OP_REM,  32'd5,        32'd0,        32'd0,        1'b1, 1,  "rem_off"});
        vecs.push_back('{OP_REMU, 32'd5,        32'd3,        32'd0,        1'b1, 1,  "remu_off"});
`endif

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_op_err", op_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);

        // Vector table, consumer always ready
        foreach (vecs[i])
            issue(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].res, vecs[i].err, vecs[i].lat,
                  vecs[i].nm, 1'b1, acc0);
        drain();

        // Back-to-back accept in the DONE cycle
        issue(OP_ADD, 32'd10, 32'd20, 32'd30, 1'b0, 1, "b2b_first", 1'b1, acc0);
        issue(OP_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1, "b2b_second", 1'b1, acc1);
        chk("b2b_accept_cycle", acc1, acc0 + 1);
        drain();

        // Backpressure: result held, in_ready low while out_ready is 0
        @(negedge clk);
        out_ready = 1'b0;
        issue(OP_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 1, "bp_add", 1'b1, acc0);
        vcount = 0;
        while (!out_valid && vcount < 10) begin
            @(negedge clk); #2; vcount++;
        end
        repeat (5) begin
            @(negedge clk); #2;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_result", result, 3);
            chk("bp_in_ready", in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        drain();

        // in_ready stays low while multiplying
        issue(OP_MUL, 32'd3, 32'd5, 32'd15, 1'b0, 33, "busy_mul", 1'b1, acc0);
        repeat (5) begin
            @(negedge clk); #2;
            chk("busy_in_ready", in_ready, 0);
        end
        drain();

        // Reset in the middle of an iterative op aborts it
`ifdef SEQ_ALU_DIV_EN
        issue(OP_DIV, 32'd100, 32'd3, 32'd33, 1'b0, 33, "rst_div", 1'b0, acc0);
`else
        issue(OP_MUL, 32'd100, 32'd3, 32'd300, 1'b0, 33, "rst_mul", 1'b0, acc0);
`endif
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_result", result, 0);
        chk("midrst_state", state_dbg, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 1);
        vcount = 0;
        repeat (40) begin
            @(negedge clk); #2;
            if (out_valid) vcount++;
        end
        chk("midrst_no_output", vcount, 0);

        // Random traffic with random consumer backpressure
        rdy_rand = 1'b1;
        repeat (60) begin
            op = 6'($urandom_range(0, 18));
            if (op == 6'd18) op = OP_BAD;
            x = pick();
            y = pick();
            model(op, x, y, er, ee, el);
            issue(op, x, y, er, ee, el, $sformatf("rand_op%0d", op), 1'b1, acc0);
        end
        drain();
        rdy_rand = 1'b0;
        @(negedge clk); #1;
        out_ready = 1'b1;

        // Four multiplier bits per iteration
        mul4(OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        "m4_mul_ff");
        mul4(OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        "m4_mulh_ff");
        mul4(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "m4_mulhu_ff");
        mul4(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "m4_mulhsu_ff");
        mul4(OP_MUL,    32'd3,        32'd4,        32'd12,       "m4_mul_3x4");

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
